// File: rtl/ps2_key_state.sv
// PS/2 keyboard receiver and set-2 scan-code decoder.
// Delivers held-key levels for W, S, Up, Down and P to the main game FSM,
// plus the raw byte stream (scan_code/code_valid) and a frame error pulse.
// Everything runs in the system clock domain; the PS/2 pins are asynchronous.

module ps2_key_state #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w_state,
    output logic       s_state,
    output logic       Ua_state,
    output logic       Da_state,
    output logic       Pause,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Two-flop synchronizers; the _p1 flops are the first usable samples.
    logic ps2_clk_p0, ps2_clk_p1;
    logic ps2_data_p0, ps2_data_p1;

    // Glitch filter state: filtered clock, its one-cycle delay, run counter.
    logic          clk_f;
    logic          clk_f_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    // Frame receiver state.
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [TW-1:0] idle_cnt;

    // Decoder prefix flags: E0 seen (extended) and F0 seen (break).
    logic ext;
    logic brk;

    // Accept a frame only with start=0, odd parity over data+parity, stop=1.
    // The shift register holds start in bit 0, data in 8:1, parity in 9.
    function automatic logic frame_ok(input logic [9:0] sr, input logic stop);
        return (sr[0] == 1'b0) && (^sr[9:1] == 1'b1) && (stop == 1'b1);
    endfunction

    // Bring both PS/2 pins into the clk domain; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_f    <= 1'b1;
            clk_f_d  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (ps2_clk_p1 != clk_f) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_f    <= ~clk_f;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // One-cycle strobe on a 1->0 transition of the filtered clock.
    assign fall = clk_f_d & ~clk_f;

    // Shift in frame bits, check on the stop bit, decode bytes into key levels,
    // and abandon a stalled partial frame after TIMEOUT_CYCLES idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            idle_cnt   <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            scan_code  <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            w_state    <= 1'b0;
            s_state    <= 1'b0;
            Ua_state   <= 1'b0;
            Da_state   <= 1'b0;
            Pause      <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok(shift, ps2_data_p1)) begin
                        scan_code  <= shift[8:1];
                        code_valid <= 1'b1;
                        case (shift[8:1])
                            8'hE0: ext <= 1'b1;
                            8'hF0: brk <= 1'b1;
                            default: begin
                                // Plain and E0-extended codes live in separate
                                // tables so keypad 75/72 and E0 1D/1B never alias.
                                if (!ext) begin
                                    case (shift[8:1])
                                        8'h1D:   w_state <= ~brk;
                                        8'h1B:   s_state <= ~brk;
                                        8'h4D:   Pause   <= ~brk;
                                        default: ;
                                    endcase
                                end else begin
                                    case (shift[8:1])
                                        8'h75:   Ua_state <= ~brk;
                                        8'h72:   Da_state <= ~brk;
                                        default: ;
                                    endcase
                                end
                                ext <= 1'b0;
                                brk <= 1'b0;
                            end
                        endcase
                    end else begin
                        // A lost byte may have been a prefix or its target, so
                        // drop the prefixes but keep every held level.
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                    end
                end else begin
                    shift   <= {ps2_data_p1, shift[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYCLES)) begin
                    bit_cnt   <= '0;
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                    ext       <= 1'b0;
                    brk       <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_state.md
# ps2_key_state

PS/2 keyboard receiver and scan-code decoder. Produces the held-key level signals `w_state`, `s_state`, `Ua_state`, `Da_state` and `Pause` that the main menu/game state machine consumes. The main FSM does its own rising-edge detection, so this block only has to deliver clean, glitch-free press/release levels. It sits between the board PS/2 pins and the main FSM, in the system clock domain.

## Interface

**Parameters**
- `FILTER_LEN`, default 8: consecutive equal synchronized samples required before filtered `ps2_clk` changes level.
- `TIMEOUT_CYCLES`, default 200_000: idle cycles in mid-frame (2 ms at 100 MHz) before the partial frame is abandoned.

**Ports**
- `clk`, in, 1: system clock (100 MHz).
- `rst`, in, 1: asynchronous, active-high reset.
- `ps2_clk`, in, 1: raw PS/2 clock pin, asynchronous.
- `ps2_data`, in, 1: raw PS/2 data pin, asynchronous.
- `w_state`, out, 1: W key held (set-2 code 1D).
- `s_state`, out, 1: S key held (1B).
- `Ua_state`, out, 1: Up arrow held (E0 75).
- `Da_state`, out, 1: Down arrow held (E0 72).
- `Pause`, out, 1: P key held (4D).
- `scan_code`, out, 8: last valid received byte.
- `code_valid`, out, 1: one-cycle pulse when `scan_code` updates.
- `frame_err`, out, 1: one-cycle pulse when a frame is rejected or times out.

## Operation

**Reset values**
- All outputs 0, `scan_code` = 8'h00.
- Bit counter, prefix flags, filter and timeout counters all 0.
- Filtered clock = 1.

**Input conditioning**
- Both pins pass through a 2-flop synchronizer.
- Filtered clock toggles only after `FILTER_LEN` consecutive synchronized samples differ from its current value.
- A falling edge is filtered clock going 1→0. On that cycle the synchronized data bit is sampled.

**Frame receiver**
- Frame is 11 bits: start (0), data[0..7] LSB first, odd parity, stop (1).
- A 4-bit counter counts 0..10.
- Frame is accepted only if start==0, XOR of data and parity ==1, and stop==1.
- On the stop bit: the counter returns to 0. Then either a valid byte is delivered, or `frame_err` pulses and the byte is discarded.
- Timeout: while the counter ≠0, an idle counter increments each cycle with no falling edge and clears on a falling edge. On reaching `TIMEOUT_CYCLES`, the counter → 0, `frame_err` pulses, and both prefix flags clear.

**Decoder (per valid byte)**
- E0: set `ext`.
- F0: set `brk`.
- Any other byte: look up (`ext`, byte). A matching key output is set to ~`brk`. Then clear `ext` and `brk`.
- Unmapped codes change no key output, but still clear the prefixes.
- 1D or 1B preceded by E0 does not match W/S. 75 or 72 without E0 (keypad) does not match the arrows.
- Typematic repeats (repeated make codes) re-set an already-set level. No visible change.
- A rejected frame clears `ext` and `brk`. Key levels are kept.
- Several keys may be held simultaneously. Each level is independent.

## Timing
- Falling edge detected at cycle T for the stop bit → `scan_code`, `code_valid` and the key level all update at T+1.
- `frame_err` pulses at T+1 for rejects, and one cycle after the timeout count is reached.
- End-to-end pin-to-level latency: 2 (sync) + `FILTER_LEN` + 1 cycles after the last pin clock edge.
- Reset asserted mid-frame: all state clears immediately and asynchronously. The next frame is received from its start bit. Any remainder of the interrupted frame either times out or fails its checks.
- At most one byte completes per cycle, so there are no simultaneous-byte cases. A timeout and a falling edge cannot coincide because the edge clears the idle counter first.

## Test plan
- Reset: assert `rst` mid-frame → all outputs 0 within the same cycle. A following clean frame 1D → `w_state`=1, `code_valid` pulse with `scan_code`=8'h1D.
- Make/break: 1D then F0 1D → `w_state` 1 then 0. Also verify 4D → `Pause`=1, and F0 4D → `Pause`=0.
- Extended: E0 75 → `Ua_state`=1 while `w_state` is unchanged. E0 F0 75 → `Ua_state`=0. Plain 75 → no output change.
- Errors: frame with bad parity on 1B → `frame_err` pulse, no `code_valid`, `s_state` stays 0. Bad stop bit behaves the same way.
- Timeout: send 5 bits then stop for `TIMEOUT_CYCLES`+10 cycles → one `frame_err`. A following full 72 frame with E0 prefix → `Da_state`=1.
- Glitch: ps2_clk low pulse of `FILTER_LEN`−1 cycles → no bit counted. Held W, S, Up, Down → all four levels 1 simultaneously.
